adc_spi_reader: RTL and testbench

Front-end serial ADC controller that sits directly upstream of the 8-sample averaging acquisition stage. It answers that stage's `adc_data_req` / `adc_data_rdy` handshake by running one 16-bit SPI read frame on an AD7476-style converter. The frame is 4 leading zeros followed by 12 data bits, MSB first. The block then presents the 12-bit sample in parallel with a one-cycle ready pulse.

---
 rtl/adc_spi_reader.sv | 203 ++++++++++++++++++++
 tb/tb_adc_spi_reader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI read-frame controller for an AD7476-style serial ADC.
// Each accepted request edge runs one 16-bit frame (4 leading zeros plus
// 12 data bits, MSB first) and returns the sample with a one-cycle ready pulse.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | cs_n high, sclk high, waiting for a request rising edge
// CS_SETUP | cs_n low for D cycles before the first sclk falling edge
// SHIFT    | 16 bits, each D cycles sclk low then D cycles sclk high
// CS_HOLD  | sclk high, cs_n still low for D cycles, then publish result
// QUIET    | cs_n high for D cycles of converter quiet time
module adc_spi_reader #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        adc_data_req_i,
  output logic        adc_data_rdy_o,
  output logic [11:0] adc_data_o,
  output logic        frame_err_o,
  output logic        busy_o,
  output logic        spi_cs_n_o,
  output logic        spi_sclk_o,
  input  logic        spi_miso_i
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CS_SETUP = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] CS_HOLD  = 3'd3;
  localparam logic [2:0] QUIET    = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [3:0]       bit_cnt;
  logic [3:0]       bit_nxt;
  logic [15:0]      shift_reg;
  logic             req_d;
  logic             req_edge;
  logic             phase_done;
  logic             bit_last;
  logic             cs_n;
  logic             sclk;
  logic             busy;
  logic             rdy;
  logic [11:0]      data;
  logic             err;

  // Request edge qualifier; reset loads 1 so a request held through reset is not an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_d <= 1'b1;
    end else begin
      req_d <= adc_data_req_i;
    end
  end

  // Decode of the current phase position and the request edge.
  always_comb begin
    req_edge   = adc_data_req_i & ~req_d;
    phase_done = (div_cnt == DIV_LAST);
    bit_last   = (bit_cnt == 4'd15);
  end

  // Next-state and counter logic; div_cnt wraps every D cycles in every active state.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    case (state)
      IDLE: begin
        div_nxt = '0;
        bit_nxt = '0;
        if (req_edge) begin
          state_nxt = CS_SETUP;
        end
      end
      CS_SETUP: begin
        div_nxt = phase_done ? '0 : div_cnt + DIV_W'(1);
        if (phase_done) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        div_nxt = phase_done ? '0 : div_cnt + DIV_W'(1);
        // A bit ends at the close of its high phase.
        if (phase_done && sclk) begin
          bit_nxt = bit_cnt + 4'd1;
          if (bit_last) begin
            state_nxt = CS_HOLD;
          end
        end
      end
      CS_HOLD: begin
        div_nxt = phase_done ? '0 : div_cnt + DIV_W'(1);
        if (phase_done) begin
          state_nxt = QUIET;
        end
      end
      QUIET: begin
        div_nxt = phase_done ? '0 : div_cnt + DIV_W'(1);
        if (phase_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        div_nxt   = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
    end
  end

  // SCLK generation and MISO capture on the edge that raises SCLK.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sclk      <= 1'b1;
      shift_reg <= '0;
    end else begin
      case (state)
        CS_SETUP: begin
          if (phase_done) begin
            sclk <= 1'b0;
          end
        end
        SHIFT: begin
          if (phase_done) begin
            if (!sclk) begin
              sclk      <= 1'b1;
              shift_reg <= {shift_reg[14:0], spi_miso_i};
            end else if (!bit_last) begin
              sclk <= 1'b0;
            end
          end
        end
        default: begin
          sclk <= 1'b1;
        end
      endcase
    end
  end

  // Chip select and busy span: cs_n low from acceptance to end of CS_HOLD, busy through QUIET.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cs_n <= 1'b1;
      busy <= 1'b0;
    end else begin
      if (state == IDLE && req_edge) begin
        cs_n <= 1'b0;
        busy <= 1'b1;
      end
      if (state == CS_HOLD && phase_done) begin
        cs_n <= 1'b1;
      end
      if (state == QUIET && phase_done) begin
        busy <= 1'b0;
      end
    end
  end

  // Result publication at the end of CS_HOLD with a single-cycle ready pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdy  <= 1'b0;
      data <= '0;
      err  <= 1'b0;
    end else begin
      rdy <= 1'b0;
      if (state == CS_HOLD && phase_done) begin
        rdy  <= 1'b1;
        data <= shift_reg[11:0];
        err  <= |shift_reg[15:12];
      end
    end
  end

  assign adc_data_rdy_o = rdy;
  assign adc_data_o     = data;
  assign frame_err_o    = err;
  assign busy_o         = busy;
  assign spi_cs_n_o     = cs_n;
  assign spi_sclk_o     = sclk;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: a timeline model (offsets from the acceptance edge)
// checks every cycle of a D=4 instance; a D=2 instance covers the long request.
module tb_adc_spi_reader;

  localparam int D  = 4;
  localparam int D2 = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        miso = 1'b0;
  logic        rdy;
  logic [11:0] data;
  logic        err;
  logic        busy;
  logic        cs_n;
  logic        sclk;

  logic        req2 = 1'b0;
  logic        miso2 = 1'b0;
  logic        rdy2;
  logic [11:0] data2;
  logic        err2;
  logic        busy2;
  logic        cs_n2;
  logic        sclk2;

  always #5 clk = ~clk;

  adc_spi_reader #(.CLK_DIV(D)) dut (
    .clk_i(clk), .reset_i(reset), .adc_data_req_i(req),
    .adc_data_rdy_o(rdy), .adc_data_o(data), .frame_err_o(err),
    .busy_o(busy), .spi_cs_n_o(cs_n), .spi_sclk_o(sclk), .spi_miso_i(miso)
  );

  adc_spi_reader #(.CLK_DIV(D2)) dut2 (
    .clk_i(clk), .reset_i(reset), .adc_data_req_i(req2),
    .adc_data_rdy_o(rdy2), .adc_data_o(data2), .frame_err_o(err2),
    .busy_o(busy2), .spi_cs_n_o(cs_n2), .spi_sclk_o(sclk2), .spi_miso_i(miso2)
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ADC models: latch the word on CS fall, present the next bit on each SCLK fall.
  logic [15:0] next_word = 16'h0;
  logic [15:0] cur_word = 16'h0;
  int bit_idx = 0;
  int falls0 = 0;
  int falls0_total = 0;
  int cs0_falls = 0;
  int rdy0_total = 0;

  always @(negedge cs_n) begin
    cur_word = next_word;
    bit_idx = 0;
    falls0 = 0;
    cs0_falls++;
  end

  always @(negedge sclk) begin
    falls0++;
    falls0_total++;
    if (bit_idx < 16) begin
      miso = cur_word[15 - bit_idx];
      bit_idx++;
    end
  end

  always @(negedge clk) if (rdy) rdy0_total++;

  logic [15:0] word2 = 16'h8123;
  int bit_idx2 = 0;
  int falls2_total = 0;

  always @(negedge cs_n2) bit_idx2 = 0;

  always @(negedge sclk2) begin
    falls2_total++;
    if (bit_idx2 < 16) begin
      miso2 = word2[15 - bit_idx2];
      bit_idx2++;
    end
  end

  // Reference model: a frame is just an acceptance cycle k plus fixed offsets.
  logic        m_active = 1'b0;
  logic        m_reqd = 1'b1;
  logic        m_err = 1'b0;
  logic [11:0] m_data = 12'h0;
  logic [15:0] m_word = 16'h0;
  int          m_k = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_active = 1'b0;
      m_reqd = 1'b1;
      m_data = 12'h0;
      m_err = 1'b0;
    end else begin
      if (m_active) begin
        if (cyc - m_k == 34 * D) begin
          m_data = m_word[11:0];
          m_err = |m_word[15:12];
        end
        if (cyc - m_k == 35 * D) m_active = 1'b0;
      end else if (req && !m_reqd) begin
        m_active = 1'b1;
        m_k = cyc;
        m_word = next_word;
      end
      m_reqd = req;
    end
  end

  int   t_off;
  logic e_cs, e_sclk, e_rdy;

  always @(negedge clk) begin
    if (chk_en) begin
      t_off  = cyc - m_k;
      e_cs   = !(m_active && t_off < 34 * D);
      e_sclk = !(m_active && t_off >= D && t_off < 32 * D && ((t_off - D) % (2 * D)) < D);
      e_rdy  = m_active && (t_off == 34 * D);
      check("cycle {cs_n,sclk,busy,rdy,err,data}",
            {15'd0, cs_n, sclk, busy, rdy, err, data},
            {15'd0, e_cs, e_sclk, m_active, e_rdy, m_err, m_data});
    end
  end

  task automatic wait_rdy(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rdy) begin
        at = cyc;
        break;
      end
    end
    check("rdy_within_budget", 32'(at >= 0), 32'd1);
  endtask

  task automatic do_frame(input logic [15:0] w, output int lat);
    int k, at;
    next_word = w;
    @(negedge clk);
    req = 1'b1;
    k = cyc + 1;
    tick(2);
    req = 1'b0;
    wait_rdy(300, at);
    lat = (at < 0) ? -1 : at - k;
    tick(6);
  endtask

  initial begin
    int k, at, lat, r0, f0, c0, cnt;

    reset = 1'b1;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("reset_cs_n", 32'(cs_n), 32'd1);
    check("reset_sclk", 32'(sclk), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    reset = 1'b0;
    tick(2);

    // Basic read of 0x0ABC.
    next_word = 16'h0ABC;
    @(negedge clk);
    req = 1'b1;
    k = cyc + 1;
    wait_rdy(300, at);
    check("basic_rdy_latency", at - k, 136);
    check("basic_data", 32'(data), 32'h0ABC);
    check("basic_err", 32'(err), 32'd0);
    check("basic_sclk_pulses", falls0, 16);
    tick(3);
    check("basic_busy_k139", 32'(busy), 32'd1);
    tick(1);
    check("basic_busy_k140", 32'(busy), 32'd0);
    req = 1'b0;
    tick(3);

    // Frame error, then a clean frame.
    do_frame(16'h5123, lat);
    check("ferr_latency", lat, 136);
    check("ferr_data", 32'(data), 32'h123);
    check("ferr_flag", 32'(err), 32'd1);
    do_frame(16'h0FFF, lat);
    check("clean_data", 32'(data), 32'hFFF);
    check("clean_flag", 32'(err), 32'd0);

    // Second request edge while busy is dropped.
    next_word = 16'($urandom);
    @(negedge clk);
    req = 1'b1;
    k = cyc + 1;
    r0 = rdy0_total;
    f0 = falls0_total;
    tick(3);
    req = 1'b0;
    while (cyc < k + 49) @(negedge clk);
    req = 1'b1;
    tick(3);
    req = 1'b0;
    while (cyc < k + 199) @(negedge clk);
    check("busy_req_rdy_count", rdy0_total - r0, 1);
    check("busy_req_sclk_pulses", falls0_total - f0, 16);
    tick(2);

    // Back-to-back frames at k and k+141.
    next_word = 16'h0001;
    @(negedge clk);
    req = 1'b1;
    k = cyc + 1;
    tick(3);
    req = 1'b0;
    next_word = 16'h0FFE;
    wait_rdy(300, at);
    check("b2b_rdy1_at", at - k, 136);
    check("b2b_data1", 32'(data), 32'h001);
    while (cyc < k + 140) @(negedge clk);
    req = 1'b1;
    wait_rdy(300, at);
    check("b2b_rdy2_at", at - k, 277);
    check("b2b_data2", 32'(data), 32'hFFE);
    tick(2);
    req = 1'b0;
    tick(6);

    // Reset mid-shift with the request still held.
    next_word = 16'($urandom);
    @(negedge clk);
    req = 1'b1;
    k = cyc + 1;
    while (cyc < k + 59) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_cs_n", 32'(cs_n), 32'd1);
    check("rst_mid_sclk", 32'(sclk), 32'd1);
    check("rst_mid_data", 32'(data), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    r0 = rdy0_total;
    c0 = cs0_falls;
    tick(150);
    check("rst_mid_no_rdy", rdy0_total - r0, 0);
    check("rst_mid_no_frame", cs0_falls - c0, 0);
    req = 1'b0;
    tick(2);
    do_frame(16'h0765, lat);
    check("rst_after_latency", lat, 136);
    check("rst_after_data", 32'(data), 32'h765);

    // Long request on the D=2 instance.
    @(negedge clk);
    req2 = 1'b1;
    k = cyc + 1;
    cnt = 0;
    at = -1;
    f0 = falls2_total;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rdy2) begin
        cnt++;
        at = cyc;
      end
    end
    check("long_rdy_count", cnt, 1);
    check("long_rdy_at", at - k, 68);
    check("long_data", 32'(data2), 32'h123);
    check("long_err", 32'(err2), 32'd1);
    check("long_sclk_pulses", falls2_total - f0, 16);
    check("long_busy_end", 32'(busy2), 32'd0);
    req2 = 1'b0;
    tick(2);

    // Randomized requests, data words and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!m_active) next_word = 16'($urandom);
      if ($urandom_range(0, 7) == 0) req = ~req;
      reset = ($urandom_range(0, 599) == 0);
    end
    reset = 1'b0;
    req = 1'b0;
    tick(160);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
